div_iter: RTL and testbench



---
 rtl/div_iter.sv | 141 ++++++++++++++
 tb/tb_div_iter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring divider for DIV/DIVU, one quotient
//            bit per cycle; result packed as {remainder, quotient}.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_divzero = 2'd1;
    localparam logic [1:0] c_st_busy    = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_quo;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic               w_accept;

    assign w_accept = start_i & ~annul_i;
    assign w_abs_a  = (signed_div_i & a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_abs_b  = (signed_div_i & b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Trial subtraction one bit wider than the operands so the MSB is the borrow.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};
    assign w_quo_fix  = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_fix  = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = (b == '0) ? c_st_divzero : c_st_busy;
                end
            end
            c_st_divzero: w_state_next = annul_i ? c_st_idle : c_st_done;
            c_st_busy: begin
                if (annul_i) begin
                    w_state_next = c_st_idle;
                end else if (r_cnt == c_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_a_raw  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_quo   <= w_abs_a;
                        r_dvs   <= w_abs_b;
                        r_rem   <= '0;
                        r_a_raw <= a;
                        r_neg_q <= signed_div_i & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= signed_div_i & a[WIDTH-1];
                    end
                end
                c_st_divzero: begin
                    if (!annul_i) begin
                        r_result <= {r_a_raw, {WIDTH{1'b1}}};
                    end
                end
                c_st_busy: begin
                    if (!annul_i) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Purpose  : Directed self-checking bench for div_iter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] a;
    logic [31:0] b;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .a            (a),
        .b            (b),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one op, scramble operands after acceptance, measure edges from E0 to ready_o.
    task automatic run(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [63:0] exp_res, input int exp_edges, input string tag);
        int  edges;
        bit  got;
        @(negedge clk);
        signed_div_i = sgn;
        a            = aa;
        b            = bb;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        a            = $urandom;
        b            = $urandom;
        signed_div_i = ~sgn;
        edges        = 0;
        got          = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready_o) got = 1'b1;
        end
        start_i = 1'b0;
        check({tag, " latency"}, 64'(edges), 64'(exp_edges));
        check({tag, " result"}, result_o, exp_res);
        @(posedge clk);
        #1;
        check({tag, " ready drop"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        int          seen;
        logic [63:0] prior;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        a            = '0;
        b            = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                   32, "u100_7");
        run(1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD},    32, "s-7_2");
        run(1'b1, 32'd7,          32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD},   32, "s7_-2");
        run(1'b1, 32'hFFFF_FF9C,  32'd7,        {32'hFFFF_FFFE, 32'hFFFF_FFF2},    32, "s-100_7");
        run(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0, 32'h8000_0000},           32, "s_ovf");
        run(1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0, 32'hFFFF_FFFF},            32, "umax_1");
        run(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0},           32, "u8_max");
        run(1'b0, 32'h0000_1234,  32'd0,        {32'h0000_1234, 32'hFFFF_FFFF},     1, "divzero");

        // Annul in the 10th BUSY cycle, then confirm nothing completes.
        prior = result_o;
        @(negedge clk);
        signed_div_i = 1'b0;
        a            = 32'd1000;
        b            = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        seen    = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        check("annul ready", 64'(seen), 64'd0);
        check("annul result", result_o, prior);

        // start together with annul in IDLE must not launch anything.
        @(negedge clk);
        a       = 32'd20;
        b       = 32'd4;
        start_i = 1'b1;
        annul_i = 1'b1;
        seen    = 0;
        repeat (36) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        check("start+annul ready", 64'(seen), 64'd0);
        check("start+annul result", result_o, prior);

        run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, "u9_3");

        // Asynchronous reset between edges while BUSY.
        @(negedge clk);
        signed_div_i = 1'b0;
        a            = 32'd77;
        b            = 32'd5;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst ready", 64'(ready_o), 64'd0);
        check("async rst result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 32, "u50_5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
